// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, field layout and helpers for the UART receive controller
//
// Contents:
//   rx_state_e : controller FSM state encoding
//   cfg_t      : receiver configuration word {stop, parity[1:0], baud[1:0]}
//   cnt_t      : statistics counter type, CNT_W bits wide
//   sat_inc    : saturating increment for cnt_t
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_CLEAR   = 2'd2
    } rx_state_e;

    localparam int CFG_W = 5;

    // Bit 4 = stop, bits 3:2 = parity, bits 1:0 = baud
    typedef struct packed {
        logic       stop;
        logic [1:0] parity;
        logic [1:0] baud;
    } cfg_t;

    localparam int CNT_W = 8;
    typedef logic [CNT_W-1:0] cnt_t;

    // Counters stick at all-ones rather than wrapping back to zero
    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : cnt_t'(v + 1'b1);
    endfunction

endpackage

// File: rtl/uart_rx_controller_if.sv
// rtl/uart_rx_controller_if.sv - received-byte output stream (valid/ready handshake)
//
// Signals:
//   out_valid : FIFO head is valid
//   out_ready : consumer accepts the head
//   out_data  : head byte
//   out_perr  : parity-error tag of the head
// Modports: master (controller side), slave (consumer side)
interface uart_rx_controller_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_perr;

    modport master (output out_valid, output out_data, output out_perr, input out_ready);
    modport slave  (input out_valid, input out_data, input out_perr, output out_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO with a registered head word
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   push_i     : write din_i (ignored when full without a simultaneous pop)
//   din_i      : write data
//   pop_i      : remove the head (ignored when empty)
//   dout_o     : head word, driven straight from a register
//   count_o    : occupancy, 0..DEPTH
module uart_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             pop_ok, push_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok);
    // Pointers are PW bits and DEPTH is a power of two, so +1 wraps on its own
    assign rd_nxt  = rd_ptr_q + 1'b1;

    // The head register always mirrors mem_q[rd_ptr_q] while non-empty; on a pop
    // it must be reloaded from the next slot, or from the incoming word if the
    // FIFO held only the outgoing entry.
    always_comb begin
        head_d = head_q;
        if (pop_ok) begin
            if (count_q > CW'(1)) begin
                head_d = mem_q[rd_nxt];
            end else if (push_ok) begin
                head_d = din_i;
            end
        end else if (push_ok && (count_q == '0)) begin
            head_d = din_i;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_nxt;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    assign dout_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/uart_rx_controller.sv
// rtl/uart_rx_controller.sv - UART receive controller: byte capture, flag handshake, config deferral, output FIFO
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   flag_data_received    : receiver byte-complete flag (level, held until cleared)
//   flag_parity_error     : receiver parity error for the current byte
//   rx_data               : receiver byte
//   clear_flag            : asks the receiver to drop its flags (high in CLEAR)
//   config_reg            : active receiver configuration {stop, parity, baud}
//   cfg_in, cfg_wr        : new configuration value and its one-cycle write strobe
//   out_if                : output stream of buffered bytes (valid/ready)
//   fifo_count            : FIFO occupancy
//   overrun_cnt, perr_cnt : saturating statistics counters
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter int         DROP_PERR  = 1,
    parameter logic [4:0] CFG_RESET  = 5'b00111
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flag_data_received,
    input  logic                        flag_parity_error,
    input  logic [7:0]                  rx_data,
    output logic                        clear_flag,
    output logic [4:0]                  config_reg,
    input  logic [4:0]                  cfg_in,
    input  logic                        cfg_wr,
    uart_rx_controller_if.master        out_if,
    output logic [4:0]                  fifo_count,
    output logic [7:0]                  overrun_cnt,
    output logic [7:0]                  perr_cnt
);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    rx_state_e state_q, state_d;

    cfg_t      cfg_q, cfg_d;
    cfg_t      pending_cfg_q, pending_cfg_d;
    logic      pending_q, pending_d;
    cnt_t      overrun_q, overrun_d;
    cnt_t      perr_q, perr_d;

    logic          capture, cfg_apply;
    logic          pop, push, fifo_full, drop_byte;
    logic [8:0]    fifo_head;
    logic [CW-1:0] fifo_cnt;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (flag_data_received)  state_d = ST_CAPTURE;
            ST_CAPTURE:                          state_d = ST_CLEAR;
            ST_CLEAR:   if (!flag_data_received) state_d = ST_IDLE;
            default:                             state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        clear_flag = (state_q == ST_CLEAR);
        capture    = (state_q == ST_CAPTURE);
        // A waiting byte wins over a pending config, so config only moves in a quiet IDLE
        cfg_apply  = (state_q == ST_IDLE) && !flag_data_received && pending_q;
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        pop       = out_if.out_valid && out_if.out_ready;
        fifo_full = (fifo_cnt == CW'(FIFO_DEPTH));
        // Parity-dropped bytes never reach the FIFO, so they cannot overrun it
        drop_byte = capture && (DROP_PERR != 0) && flag_parity_error;
        push      = capture && !drop_byte && (!fifo_full || pop);

        overrun_d = overrun_q;
        if (capture && !drop_byte && fifo_full && !pop) begin
            overrun_d = sat_inc(overrun_q);
        end

        perr_d = perr_q;
        if (capture && flag_parity_error) begin
            perr_d = sat_inc(perr_q);
        end

        cfg_d = cfg_apply ? pending_cfg_q : cfg_q;

        // A strobe landing on the apply cycle becomes the next pending value
        pending_cfg_d = cfg_wr ? cfg_t'(cfg_in) : pending_cfg_q;
        pending_d     = cfg_wr ? 1'b1 : (cfg_apply ? 1'b0 : pending_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q         <= cfg_t'(CFG_RESET);
            pending_cfg_q <= cfg_t'(CFG_RESET);
            pending_q     <= 1'b0;
            overrun_q     <= '0;
            perr_q        <= '0;
        end else begin
            cfg_q         <= cfg_d;
            pending_cfg_q <= pending_cfg_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            perr_q        <= perr_d;
        end
    end

    uart_sync_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .din_i   ({flag_parity_error, rx_data}),
        .pop_i   (pop),
        .dout_o  (fifo_head),
        .count_o (fifo_cnt)
    );

    assign out_if.out_valid = (fifo_cnt != '0);
    assign out_if.out_data  = fifo_head[7:0];
    assign out_if.out_perr  = fifo_head[8];

    assign config_reg  = cfg_q;
    assign fifo_count  = 5'(fifo_cnt);
    assign overrun_cnt = overrun_q;
    assign perr_cnt    = perr_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// tb/tb_uart_rx_controller.sv - self-checking bench for uart_rx_controller (DROP_PERR=1 and DROP_PERR=0 instances)
module tb_uart_rx_controller;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flag = 1'b0;
    logic       perr = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [4:0] cfg_in = 5'b0;
    logic       cfg_wr = 1'b0;
    logic       out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_rx_controller_if if_drop ();
    uart_rx_controller_if if_keep ();
    assign if_drop.out_ready = out_ready;
    assign if_keep.out_ready = out_ready;

    // index 0 = DROP_PERR=1 instance, index 1 = DROP_PERR=0 instance
    logic       cf [2];
    logic [4:0] cr [2];
    logic [4:0] fc [2];
    logic [7:0] oc [2];
    logic [7:0] pc [2];
    logic       ov [2];
    logic       op [2];
    logic [7:0] od [2];

    assign ov[0] = if_drop.out_valid;
    assign od[0] = if_drop.out_data;
    assign op[0] = if_drop.out_perr;
    assign ov[1] = if_keep.out_valid;
    assign od[1] = if_keep.out_data;
    assign op[1] = if_keep.out_perr;

    uart_rx_controller #(.FIFO_DEPTH(DEPTH), .DROP_PERR(1)) u_drop (
        .clk(clk), .reset(reset),
        .flag_data_received(flag), .flag_parity_error(perr), .rx_data(rx_data),
        .clear_flag(cf[0]), .config_reg(cr[0]), .cfg_in(cfg_in), .cfg_wr(cfg_wr),
        .out_if(if_drop), .fifo_count(fc[0]), .overrun_cnt(oc[0]), .perr_cnt(pc[0])
    );

    uart_rx_controller #(.FIFO_DEPTH(DEPTH), .DROP_PERR(0)) u_keep (
        .clk(clk), .reset(reset),
        .flag_data_received(flag), .flag_parity_error(perr), .rx_data(rx_data),
        .clear_flag(cf[1]), .config_reg(cr[1]), .cfg_in(cfg_in), .cfg_wr(cfg_wr),
        .out_if(if_keep), .fifo_count(fc[1]), .overrun_cnt(oc[1]), .perr_cnt(pc[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 waiting for a byte, 1 byte being taken, 2 waiting for the flag to drop
    int         m_phase [2];
    logic [8:0] mq      [2][$];
    logic [4:0] m_cfg   [2];
    logic [4:0] m_pcfg  [2];
    bit         m_pend  [2];
    int         m_ovr   [2];
    int         m_perr  [2];
    bit         mdl_on = 1'b0;

    always @(posedge clk) begin
        bit m_pop, m_push;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_phase[k] = 0;
                mq[k].delete();
                m_cfg[k]  = 5'b00111;
                m_pend[k] = 1'b0;
                m_ovr[k]  = 0;
                m_perr[k] = 0;
            end else begin
                m_pop  = (mq[k].size() > 0) && out_ready;
                m_push = 1'b0;
                if (m_phase[k] == 0) begin
                    if (flag) m_phase[k] = 1;
                    else if (m_pend[k]) begin
                        m_cfg[k]  = m_pcfg[k];
                        m_pend[k] = 1'b0;
                    end
                end else if (m_phase[k] == 1) begin
                    m_phase[k] = 2;
                    if (perr && m_perr[k] < 255) m_perr[k]++;
                    if (!(k == 0 && perr)) begin
                        if (mq[k].size() < DEPTH || m_pop) m_push = 1'b1;
                        else if (m_ovr[k] < 255) m_ovr[k]++;
                    end
                end else begin
                    if (!flag) m_phase[k] = 0;
                end
                if (cfg_wr) begin
                    m_pcfg[k] = cfg_in;
                    m_pend[k] = 1'b1;
                end
                if (m_pop)  void'(mq[k].pop_front());
                if (m_push) mq[k].push_back({perr, rx_data});
            end
        end
        if (reset) mdl_on = 1'b1;
    end

    always @(negedge clk) begin
        if (mdl_on) begin
            for (int k = 0; k < 2; k++) begin
                check_eq($sformatf("m%0d_clear", k), 32'(cf[k]), 32'(m_phase[k] == 2));
                check_eq($sformatf("m%0d_cfg", k), 32'(cr[k]), 32'(m_cfg[k]));
                check_eq($sformatf("m%0d_valid", k), 32'(ov[k]), 32'(mq[k].size() > 0));
                check_eq($sformatf("m%0d_count", k), 32'(fc[k]), 32'(mq[k].size()));
                check_eq($sformatf("m%0d_ovr", k), 32'(oc[k]), 32'(m_ovr[k]));
                check_eq($sformatf("m%0d_perr", k), 32'(pc[k]), 32'(m_perr[k]));
                if (mq[k].size() > 0) begin
                    check_eq($sformatf("m%0d_data", k), 32'(od[k]), 32'(mq[k][0][7:0]));
                    check_eq($sformatf("m%0d_ptag", k), 32'(op[k]), 32'(mq[k][0][8]));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic pe, input int hold);
        int n;
        flag = 1'b1; rx_data = b; perr = pe;
        step();
        n = 0;
        while (!cf[0] && n < 20) begin
            step();
            n++;
        end
        check_eq("clr_wait", 32'(cf[0]), 32'd1);
        repeat (hold) step();
        flag = 1'b0; perr = 1'b0;
        step();
        step();
    endtask

    task automatic check_reset_state(input string tag);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("%s%0d_clear", tag, k), 32'(cf[k]), 32'd0);
            check_eq($sformatf("%s%0d_cfg", tag, k), 32'(cr[k]), 32'h07);
            check_eq($sformatf("%s%0d_valid", tag, k), 32'(ov[k]), 32'd0);
            check_eq($sformatf("%s%0d_count", tag, k), 32'(fc[k]), 32'd0);
            check_eq($sformatf("%s%0d_data", tag, k), 32'(od[k]), 32'd0);
            check_eq($sformatf("%s%0d_ptag", tag, k), 32'(op[k]), 32'd0);
            check_eq($sformatf("%s%0d_ovr", tag, k), 32'(oc[k]), 32'd0);
            check_eq($sformatf("%s%0d_perr", tag, k), 32'(pc[k]), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int gap, hold;
        step();
        step();
        check_reset_state("rst");
        reset = 1'b0;
        step();

        // single byte A5: clear_flag two cycles after the flag, head valid
        flag = 1'b1; rx_data = 8'hA5; perr = 1'b0;
        step();
        check_eq("sb_clr_cap", 32'(cf[0]), 32'd0);
        step();
        check_eq("sb_clr_on", 32'(cf[0]), 32'd1);
        step();
        check_eq("sb_clr_hold", 32'(cf[0]), 32'd1);
        flag = 1'b0;
        step();
        check_eq("sb_clr_off", 32'(cf[0]), 32'd0);
        check_eq("sb_valid", 32'(ov[0]), 32'd1);
        check_eq("sb_data", 32'(od[0]), 32'hA5);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // overrun: five bytes into a depth-4 FIFO, then drain in order
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0, 0);
        check_eq("ovr_count", 32'(fc[0]), 32'd4);
        check_eq("ovr_cnt", 32'(oc[0]), 32'd1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check_eq($sformatf("ovr_drain%0d", i), 32'(od[1]), 32'(i));
            step();
        end
        out_ready = 1'b0;
        check_eq("ovr_empty", 32'(fc[1]), 32'd0);

        // parity error byte: dropped by one instance, tagged by the other
        send_byte(8'h3C, 1'b1, 1);
        check_eq("par_drop_cnt", 32'(pc[0]), 32'd1);
        check_eq("par_drop_count", 32'(fc[0]), 32'd0);
        check_eq("par_keep_cnt", 32'(pc[1]), 32'd1);
        check_eq("par_keep_tag", 32'(op[1]), 32'd1);
        check_eq("par_keep_data", 32'(od[1]), 32'h3C);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // config written during CLEAR waits for a quiet IDLE cycle
        flag = 1'b1; rx_data = 8'h5A;
        step();
        step();
        cfg_in = 5'b10100; cfg_wr = 1'b1;
        step();
        cfg_wr = 1'b0;
        check_eq("cfg_hold1", 32'(cr[0]), 32'h07);
        step();
        check_eq("cfg_hold2", 32'(cr[0]), 32'h07);
        flag = 1'b0;
        step();
        check_eq("cfg_hold3", 32'(cr[0]), 32'h07);
        step();
        check_eq("cfg_applied", 32'(cr[0]), 32'h14);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // full FIFO with a pop in the capture cycle: no overrun
        for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i), 1'b0, 0);
        flag = 1'b1; rx_data = 8'h14;
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("fp_count", 32'(fc[0]), 32'd4);
        check_eq("fp_ovr", 32'(oc[0]), 32'd1);
        check_eq("fp_head", 32'(od[0]), 32'h11);
        flag = 1'b0;
        step();
        step();
        out_ready = 1'b1; repeat (4) step(); out_ready = 1'b0;

        // counter saturation: 260 parity-error bytes, consumer stalled
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 260; i++) send_byte(8'(i), 1'b1, 0);
        check_eq("sat_keep_ovr", 32'(oc[1]), 32'd255);
        check_eq("sat_keep_perr", 32'(pc[1]), 32'd255);
        check_eq("sat_keep_count", 32'(fc[1]), 32'd4);
        check_eq("sat_drop_ovr", 32'(oc[0]), 32'd0);
        check_eq("sat_drop_perr", 32'(pc[0]), 32'd255);

        // reset in the middle of CLEAR with FIFO content and a non-default config
        cfg_in = 5'b11000; cfg_wr = 1'b1; step(); cfg_wr = 1'b0;
        step();
        step();
        check_eq("mc_cfg", 32'(cr[0]), 32'h18);
        send_byte(8'h77, 1'b0, 0);
        flag = 1'b1; rx_data = 8'h88;
        step();
        step();
        check_eq("mc_in_clear", 32'(cf[0]), 32'd1);
        reset = 1'b1; flag = 1'b0;
        step();
        reset = 1'b0;
        check_reset_state("mc");

        // randomized receiver traffic, consumer stalls, config writes, rare resets
        gap = 0;
        hold = 0;
        for (int c = 0; c < 2500; c++) begin
            out_ready = ($urandom_range(0, 2) == 0);
            cfg_wr    = ($urandom_range(0, 7) == 0);
            cfg_in    = 5'($urandom);
            reset     = ($urandom_range(0, 299) == 0);
            if (!flag) begin
                if (gap == 0) begin
                    flag    = 1'b1;
                    rx_data = 8'($urandom);
                    perr    = ($urandom_range(0, 3) == 0);
                    hold    = $urandom_range(0, 2);
                end else begin
                    gap--;
                end
            end else if (cf[0]) begin
                if (hold == 0) begin
                    flag = 1'b0;
                    gap  = $urandom_range(0, 3);
                end else begin
                    hold--;
                end
            end
            step();
        end
        reset = 1'b0; cfg_wr = 1'b0; flag = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
